// File: rtl/abc_pkg.sv
// -----------------------------------------------------------------------------
// abc_pkg
// Shared definitions for the ABC result collector:
//   - default FIFO depth and result width
//   - width of the batch "remaining" counter
//   - FSM state type and encoding used by abc_collector
// -----------------------------------------------------------------------------
package abc_pkg;

    localparam int DEPTH_DEFAULT = 4;   // result FIFO entries
    localparam int W_DEFAULT     = 16;  // {x,y} result width from the converter
    localparam int CNT_W         = 6;   // batch length / remaining counter width

    // FSM encoding, kept as plain constants so older tools can consume it too.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_REQ      = 2'd1;
    localparam state_t ST_WAIT_END = 2'd2;
    localparam state_t ST_STORE    = 2'd3;

endpackage

// File: rtl/collector_fifo.sv
// -----------------------------------------------------------------------------
// collector_fifo
// DEPTH x W show-ahead FIFO. The head entry is held in a register that is
// reloaded every cycle from the array (registered read), so o_rd_data always
// presents the oldest stored result while o_valid is high.
//
// Ports:
//   i_clock    clock, all state on posedge
//   i_reset    asynchronous active-high reset (empties FIFO, head = 0)
//   i_wr_en    write i_wr_data at the tail
//   i_wr_data  data to write
//   i_rd_en    pop the head (ignored while empty)
//   o_rd_data  head-of-FIFO data
//   o_valid    FIFO not empty
//   o_count    occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module collector_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_wr_en,
    input  logic [W-1:0]             i_wr_data,
    input  logic                     i_rd_en,
    output logic [W-1:0]             o_rd_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH) + 1;
    localparam logic [OW-1:0] FULL_CNT = OW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [W-1:0]  r_head;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [OW-1:0] r_count;

    logic          w_rd_fire;
    logic          w_wr_fire;
    logic [AW-1:0] w_rd_ptr_next;
    logic [OW-1:0] w_count_next;

    assign w_rd_fire = i_rd_en && (r_count != '0);
    // A write into a full FIFO only lands if a read frees the slot this cycle.
    assign w_wr_fire = i_wr_en && ((r_count < FULL_CNT) || w_rd_fire);

    // Pointers are AW bits wide, so DEPTH being a power of two makes them wrap.
    assign w_rd_ptr_next = w_rd_fire ? r_rd_ptr + AW'(1) : r_rd_ptr;
    assign w_count_next  = r_count + OW'(w_wr_fire) - OW'(w_rd_fire);

    always_ff @(posedge i_clock) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            // The next head is either the word being written right now (FIFO
            // empty, or draining its last entry) or one already in the array.
            // While the FIFO stays empty the head simply holds its old value.
            if (w_count_next != '0) begin
                if (w_wr_fire && (r_wr_ptr == w_rd_ptr_next)) begin
                    r_head <= i_wr_data;
                end else begin
                    r_head <= r_mem[w_rd_ptr_next];
                end
            end
        end
    end

    assign o_rd_data = r_head;
    assign o_valid   = (r_count != '0);
    assign o_count   = r_count;

endmodule

// File: rtl/abc_collector.sv
// -----------------------------------------------------------------------------
// abc_collector
// Runs a batch of conversions on an upstream soc/eoc converter and queues the
// results in a small FIFO for a ready/valid consumer.
//
// Ports:
//   i_clock       clock, all state on posedge
//   i_reset       asynchronous active-high reset
//   i_start       one-cycle pulse in IDLE to begin a batch
//   i_count       batch length (0..32), sampled with i_start
//   o_soc         start-of-conversion request to the converter
//   i_eoc         converter end-of-conversion (1 = idle/result valid)
//   i_res         converter result, valid while i_eoc = 1
//   o_dout        head-of-FIFO result
//   o_dout_valid  FIFO not empty
//   i_dout_ready  consumer accepts o_dout when o_dout_valid = 1
//   o_busy        batch in progress
//   o_done        one-cycle pulse when the last result of a batch is written
//                 (also pulses for a zero-length batch)
// -----------------------------------------------------------------------------
module abc_collector
    import abc_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int W     = W_DEFAULT
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_soc,
    input  logic             i_eoc,
    input  logic [W-1:0]     i_res,
    output logic [W-1:0]     o_dout,
    output logic             o_dout_valid,
    input  logic             i_dout_ready,
    output logic             o_busy,
    output logic             o_done
);

    localparam int OW = $clog2(DEPTH) + 1;
    localparam logic [OW-1:0] FULL_CNT = OW'(DEPTH);

    state_t           r_state;
    logic [CNT_W-1:0] r_remaining;
    logic [W-1:0]     r_hold;
    logic             r_soc;
    logic             r_done;
    // Set once the holding register has been pushed (or holds nothing yet),
    // so a STORE that has to wait for a free slot never writes twice.
    logic             r_written;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_remaining_next;
    logic [W-1:0]     w_hold_next;
    logic             w_soc_next;
    logic             w_done_next;
    logic             w_written_next;

    logic             w_wr_en;
    logic             w_rd_fire;
    logic [OW-1:0]    w_occ;
    logic [OW-1:0]    w_occ_after;
    logic             w_slot_free;

    assign w_wr_en   = (r_state == ST_STORE) && !r_written;
    assign w_rd_fire = o_dout_valid && i_dout_ready;

    // Occupancy as it will be after this edge, so a read in the same cycle
    // as a pending decision already counts as a freed slot.
    assign w_occ_after = w_occ + OW'(w_wr_en) - OW'(w_rd_fire);
    assign w_slot_free = (w_occ_after < FULL_CNT);

    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_hold_next      = r_hold;
        w_soc_next       = r_soc;
        w_done_next      = 1'b0;
        w_written_next   = r_written;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_count == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_remaining_next = i_count;
                        w_written_next   = 1'b1;
                        // With the FIFO full, park in STORE (nothing to write)
                        // until the consumer frees a slot.
                        w_state_next     = w_slot_free ? ST_REQ : ST_STORE;
                    end
                end
            end

            ST_REQ: begin
                // soc is only raised once the converter reports idle; this
                // also covers a conversion left running across a reset.
                if (!r_soc) begin
                    if (i_eoc) begin
                        w_soc_next = 1'b1;
                    end
                end else if (!i_eoc) begin
                    w_soc_next   = 1'b0;
                    w_state_next = ST_WAIT_END;
                end
            end

            ST_WAIT_END: begin
                if (i_eoc) begin
                    w_hold_next    = i_res;
                    w_written_next = 1'b0;
                    w_state_next   = ST_STORE;
                end
            end

            ST_STORE: begin
                if (!r_written) begin
                    w_remaining_next = r_remaining - CNT_W'(1);
                    w_written_next   = 1'b1;
                end
                if (!r_written && (r_remaining == CNT_W'(1))) begin
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_slot_free) begin
                    w_state_next = ST_REQ;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_hold      <= '0;
            r_soc       <= 1'b0;
            r_done      <= 1'b0;
            r_written   <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_hold      <= w_hold_next;
            r_soc       <= w_soc_next;
            r_done      <= w_done_next;
            r_written   <= w_written_next;
        end
    end

    collector_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_wr_en   (w_wr_en),
        .i_wr_data (r_hold),
        .i_rd_en   (i_dout_ready),
        .o_rd_data (o_dout),
        .o_valid   (o_dout_valid),
        .o_count   (w_occ)
    );

    assign o_soc  = r_soc;
    assign o_done = r_done;
    assign o_busy = (r_state != ST_IDLE);

endmodule
